// File: rtl/dtmf_pkg.sv
// Shared constants for the DTMF receive path: clock rate, period width and the
// nominal period (in 1 MHz cycles) of each of the eight DTMF frequencies.
package dtmf_pkg;

  localparam int unsigned DTMF_CLK_HZ = 1_000_000;
  localparam int unsigned PERIOD_W    = 11;
  localparam int unsigned NUM_BINS    = 8;

  typedef logic [2:0] bin_t;

  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  // Entry k is the nominal period of bin k; rows first, then columns.
  localparam logic [NUM_BINS-1:0][PERIOD_W-1:0] NOMINAL_PERIOD = {
    11'd612, 11'd677, 11'd748, 11'd827, 11'd1063, 11'd1174, 11'd1299, 11'd1435
  };

  localparam bin_t BIN_ROW_697  = 3'd0;
  localparam bin_t BIN_ROW_770  = 3'd1;
  localparam bin_t BIN_ROW_852  = 3'd2;
  localparam bin_t BIN_ROW_941  = 3'd3;
  localparam bin_t BIN_COL_1209 = 3'd4;
  localparam bin_t BIN_COL_1336 = 3'd5;
  localparam bin_t BIN_COL_1477 = 3'd6;
  localparam bin_t BIN_COL_1633 = 3'd7;

endpackage

// File: rtl/dtmf_period_classifier.sv
// Combinational period-to-bin classifier: a period hits bin k when it lies within
// TOL cycles (inclusive) of nominal period k.
module dtmf_period_classifier
  import dtmf_pkg::*;
#(
  parameter int unsigned TOL = 10
) (
  input  logic [PERIOD_W-1:0] period,
  output logic                hit,
  output bin_t                bin
);

  localparam logic [PERIOD_W-1:0] TOL_W = PERIOD_W'(TOL);

  logic [PERIOD_W-1:0] diff [NUM_BINS];

  // Bins are disjoint for the tolerances in use, so at most one entry matches.
  always_comb begin
    hit = 1'b0;
    bin = '0;
    for (int unsigned k = 0; k < NUM_BINS; k++) begin
      diff[k] = (period >= NOMINAL_PERIOD[k]) ? period - NOMINAL_PERIOD[k]
                                              : NOMINAL_PERIOD[k] - period;
      if (diff[k] <= TOL_W) begin
        hit = 1'b1;
        bin = bin_t'(k);
      end
    end
  end

endmodule

// File: rtl/dtmf_tone_detector.sv
// Measures the period of a synchronized square wave and locks onto a DTMF bin once
// CONFIRM consecutive periods classify into the same bin.
module dtmf_tone_detector
  import dtmf_pkg::*;
#(
  parameter int unsigned TOL     = 10,
  parameter int unsigned CONFIRM = 4
) (
  input  logic                inclk,
  input  logic                reset_n,
  input  logic                tone_in,
  output logic [2:0]          tone_idx,
  output logic                tone_valid,
  output logic                tone_new,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] CONFIRM_W = 4'(CONFIRM);

  logic                sync1_q, sync2_q, sync3_q, edge_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [1:0]          state_q, state_d;
  logic [3:0]          match_q, match_d;
  bin_t                cand_q, cand_d;
  bin_t                idx_d;
  logic                valid_d, new_d;
  logic [PERIOD_W-1:0] period_d;
  logic                hit;
  bin_t                bin;
  logic                cnt_sat;

  dtmf_period_classifier #(
    .TOL(TOL)
  ) u_classifier (
    .period(cnt_q),
    .hit   (hit),
    .bin   (bin)
  );

  assign cnt_sat = (cnt_q == PERIOD_MAX);
  assign cnt_d   = edge_q ? PERIOD_W'(1) : (cnt_sat ? cnt_q : cnt_q + PERIOD_W'(1));

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    cand_d   = cand_q;
    idx_d    = tone_idx;
    valid_d  = tone_valid;
    new_d    = 1'b0;
    period_d = period;
    // An edge takes precedence over timeout; a saturated count simply misses.
    if (edge_q) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
          match_d = '0;
        end
        ST_ARMED: begin
          period_d = cnt_q;
          if (!hit) begin
            match_d = '0;
          end else if (match_q != '0 && bin == cand_q) begin
            match_d = match_q + 4'd1;
          end else begin
            match_d = 4'd1;
            cand_d  = bin;
          end
          if (hit && match_d == CONFIRM_W) begin
            state_d = ST_LOCKED;
            idx_d   = cand_d;
            valid_d = 1'b1;
            new_d   = 1'b1;
          end
        end
        ST_LOCKED: begin
          period_d = cnt_q;
          if (!(hit && bin == tone_idx)) begin
            state_d = ST_ARMED;
            valid_d = 1'b0;
            match_d = hit ? 4'd1 : 4'd0;
            cand_d  = hit ? bin : cand_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && cnt_sat) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      match_d = '0;
    end
  end

  always_ff @(posedge inclk) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      edge_q     <= 1'b0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
      match_q    <= '0;
      cand_q     <= '0;
      tone_idx   <= '0;
      tone_valid <= 1'b0;
      tone_new   <= 1'b0;
      period     <= '0;
    end else begin
      sync1_q    <= tone_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      edge_q     <= sync2_q & ~sync3_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      match_q    <= match_d;
      cand_q     <= cand_d;
      tone_idx   <= idx_d;
      tone_valid <= valid_d;
      tone_new   <= new_d;
      period     <= period_d;
    end
  end

endmodule

// File: doc/dtmf_tone_detector.md
# dtmf_tone_detector

Measures the period of one incoming DTMF-band square wave on the 1 MHz system clock and classifies it as one of the eight DTMF frequencies. It is the receive-side counterpart of the tone-stepdown dividers: their square-wave outputs loop back to `tone_in` for self-test, or an external comparator output does. A tone is reported only after `CONFIRM` consecutive periods fall in the same frequency bin. A higher-level keypad decoder combines one row-detector and one column-detector instance.

## Interface
- `TOL`, 10: accepted deviation, in inclk cycles, of a measured period from a nominal period (inclusive).
- `CONFIRM`, 4: number of consecutive matching periods required to lock; range 1–15.
- `inclk`  in  1  1 MHz system clock.
- `reset_n`  in  1  Reset; synchronous, active-low.
- `tone_in`  in  1  Asynchronous square wave.
- `tone_idx`  out  3  Bin of the locked tone: 0–3 = 697/770/852/941 Hz, 4–7 = 1209/1336/1477/1633 Hz.
- `tone_valid`  out  1  High while locked.
- `tone_new`  out  1  One-cycle pulse on lock or on relock to a different bin.
- `period`  out  11  Last measured period, in inclk cycles.

## Operation
- `tone_in` passes through a 2-flop synchronizer. The rising edge is detected against a third flop, giving `edge` as a one-cycle pulse.
- `cnt` (11 bits) increments every cycle and saturates at 2047. On `edge` it loads 1, so at the next `edge` its value equals the full period.
- Nominal periods in cycles, bins 0–7: 1435, 1299, 1174, 1063, 827, 748, 677, 612.
- A period is a hit on bin k when |cnt − nominal[k]| ≤ TOL.
  - Bins are disjoint for TOL < 32.
  - If no bin matches, the measurement is a miss.
- FSM states:
  - `IDLE`: waits for the first `edge`, then goes to `ARMED` with match=0. No measurement is made on this edge.
  - `ARMED`: on each `edge`, `period` ← cnt, then:
    - Hit on the same bin as the previous hit: match increments.
    - Hit on a different bin: match ← 1, cand ← bin.
    - Miss: match ← 0.
    - When match reaches CONFIRM: go to `LOCKED`, tone_idx ← cand, tone_valid ← 1, and pulse tone_new.
  - `LOCKED`: on each `edge`, `period` ← cnt.
    - Hit on tone_idx: stay.
    - Any other result: tone_valid ← 0 and go to `ARMED`. A hit on another bin seeds match=1 with that bin; a miss sets match=0.
  - Timeout: when cnt is saturated at 2047 in `ARMED` or `LOCKED`, go to `IDLE`, tone_valid ← 0, match ← 0.
- tone_idx holds its last value when tone_valid=0. tone_new pulses only on transitions into `LOCKED`.
- Reset values: tone_idx=0, tone_valid=0, tone_new=0, period=0, cnt=0, match=0, sync flops=0, state=`IDLE`.
- Reset mid-operation has priority over every event. The detector must reacquire from `IDLE`.

## Timing
- `edge` pulses 3 inclk cycles after a `tone_in` rise: 2 synchronizer cycles plus 1 edge-register cycle.
- `period`, `tone_valid`, `tone_idx` and `tone_new` are registered. They update in the cycle after the `edge` cycle.
- Lock latency from the first rising edge is (CONFIRM × period) + 4 cycles.
- Unlock happens on the first non-matching edge, with output in the next cycle.
- Timeout unlock happens 2047 cycles after the last edge.
- If `edge` coincides with saturation, the edge wins: the 2047 period is a miss, handled as above.

## Structure
- Shared package `dtmf_pkg` holds:
  - `DTMF_CLK_HZ` = 1_000_000
  - `PERIOD_W` = 11
  - the 8-entry nominal period constant array
  - bin index localparams for rows and columns
- Sub-module `dtmf_period_classifier` is purely combinational. It takes `period` and `TOL` and outputs hit and bin. The FSM, counter and synchronizer stay in `dtmf_tone_detector`.

## Test plan
- Reset: hold reset_n=0 for 5 cycles while toggling tone_in → all outputs 0 throughout and in the first cycle after release.
- Lock: 748-cycle square wave → tone_valid=1 and tone_idx=5 one cycle after the 4th measured edge; exactly one tone_new pulse; period=748.
- Reject: 720-cycle wave, between bins 5 and 6 → tone_valid stays 0 for 20 periods and tone_new never pulses. A 758-cycle wave (edge of TOL) locks to bin 5; a 759-cycle wave never locks.
- Switch: lock on 1435 (bin 0), then change to 612 → tone_valid falls one cycle after the first 612 edge; relocks to tone_idx=7 after 3 further 612 periods, with one tone_new.
- Timeout: lock on 1063, then hold tone_in high → tone_valid falls 2047 cycles after the last edge; state returns to `IDLE`, and the next lock needs CONFIRM+1 edges.
- Reset mid-lock: assert reset_n=0 for 1 cycle while locked on bin 4 → outputs are 0 in the next cycle, and relock takes the full CONFIRM periods.
